pipelined_prefix_adder: RTL and testbench
=========================================

Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshakes on both sides.
- Successor to the fixed 8-bit combinational prefix adder in the array-multiplier datapath.
- Generalises operand width and the number of prefix levels per pipeline stage.
- Adds a subtract mode, pipeline flush and backpressure, so it can feed the accumulating multiplier and the ALU at full clock rate.

Parameters:
- WIDTH, 16, operand width in bits; must be a power of two, >= 4; L = log2(WIDTH) prefix levels.
- REG_EVERY, 2, number of prefix levels between pipeline registers; 1 <= REG_EVERY <= L.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  0: s = x + y + cin; 1: s = x + ~y + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum.
- cout  output  1  carry-out; in sub mode with cin = 1, cout = 1 means no borrow.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits cleared and all data registers zeroed. out_valid = 0, s = 0, cout = 0, in_ready = 1 (combinational, after reset). Reset can occur mid-operation; all in-flight results are discarded and none are emitted.
- Datapath:
  - Operand B is internally yb = sub ? ~y : y.
  - g0[i] = x[i] & yb[i] and p0[i] = x[i] ^ yb[i].
  - cin is folded into g0[0] as g0[0] = x0&yb0 | cin&(x0|yb0).
  - Level k (1..L) combines with span 2^(k-1). Bits below the span pass through unchanged.
  - c[i+1] = final g[i]; s = p0 ^ {c[WIDTH-1:1], cin}; cout = c[WIDTH].
- Pipeline:
  - Stage 0 registers the captured x, yb, cin and computes p0/g0.
  - One register follows each prefix level k where k is a multiple of REG_EVERY and k < L.
  - A final output register holds s and cout.
  - LAT = 2 + floor((L-1)/REG_EVERY) cycles from the accepting edge to out_valid. For defaults, LAT = 3.
- Handshake and stall:
  - adv = !out_valid | out_ready.
  - When adv = 1, every stage shifts forward, bubbles included. When adv = 0, every stage holds.
  - in_ready = adv.
  - An operand is accepted on an edge where in_valid & in_ready.
  - A result is consumed on an edge where out_valid & out_ready.
  - Throughput is one result per cycle with out_ready held high.
  - Results are delivered in acceptance order. None are dropped or duplicated.
- Output stability: while out_valid = 1 and out_ready = 0, s and cout hold stable. When out_valid = 0, s and cout hold their last values; they are not cleared.
- Flush: on the edge with flush = 1, all stage valid bits clear, and an input presented on that edge is not accepted (in_ready is forced to 0 while flush = 1). Flush takes priority over adv. Flush has no effect on data registers.
- Boundary cases:
  - x = y = all-ones with cin = 1 in add mode gives s = all-ones and cout = 1.
  - The sub mode with y = 0 and cin = 1 gives s = x and cout = 1.
  - Simultaneous acceptance and consumption on the same edge is legal and must sustain full throughput.
- Timing: no combinational path from x, y, cin or sub to any output. in_ready depends only on out_valid, out_ready and flush.

Optional Feature:
- Macro: PREFIX_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow c[WIDTH] ^ c[WIDTH-1].
  - ovf is registered alongside s and pipelined with the same valid and hold rules.
  - ovf resets to 0.
- Undefined: the port ovf and its logic are absent; all other behaviour is unchanged.

Test Plan (WIDTH = 16, REG_EVERY = 2, LAT = 3):
1. Assert rst mid-stream with 2 ops in flight → out_valid = 0, s = 0x0000, cout = 0 immediately. After release, in_ready = 1 and no stale result ever appears.
2. x = 0xFFFF, y = 0x0001, cin = 0, sub = 0, out_ready = 1 → 3 cycles later out_valid = 1, s = 0x0000, cout = 1.
3. x = 0x0005, y = 0x0007, cin = 1, sub = 1 → s = 0xFFFE, cout = 0. Then x = 0x0007, y = 0x0005 → s = 0x0002, cout = 1.
4. Issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4) and hold out_ready = 0 for 2 cycles at the first out_valid → s holds at 0x0002, in_ready = 0 during the stall. Results are then 0x0002, 0x0004, 0x0006, 0x0008 in order, with nothing lost.
5. Flush while 2 ops are in flight → out_valid = 0 on the next cycle. A new op 0x1234 + 0x1111 issued after the flush yields s = 0x2345 exactly 3 cycles after acceptance.
6. (PREFIX_ADD_OVF_EN) x = 0x7FFF, y = 0x0001 → s = 0x8000, ovf = 1, cout = 0. x = 0x8000, y = 0xFFFF → s = 0x7FFF, ovf = 1, cout = 1.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
// Optional signed-overflow output enabled by defining PREFIX_ADD_OVF_EN.
module pipelined_prefix_adder #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PREFIX_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L    = $clog2(WIDTH);
    // Stage j holds the prefix state entering levels j*REG_EVERY+1 onwards.
    localparam int NMID = (L - 1) / REG_EVERY;

    logic             outValidR;
    logic [WIDTH-1:0] sR;
    logic             coutR;
    logic             adv;
    logic             shift;

    logic [WIDTH-1:0] ybIn;
    logic [WIDTH-1:0] g0In;
    logic [WIDTH-1:0] p0In;

    logic [WIDTH-1:0] gR   [0:NMID];
    logic [WIDTH-1:0] pR   [0:NMID];
    logic [WIDTH-1:0] p0R  [0:NMID];
    logic             cinR [0:NMID];
    logic             vR   [0:NMID];

    logic [WIDTH-1:0] gOut [0:NMID];
    logic [WIDTH-1:0] pOut [0:NMID];
    logic [WIDTH-1:0] lastG;
    logic [WIDTH-1:0] sumNext;

    assign adv      = !outValidR || out_ready;
    assign shift    = adv && !flush;
    assign in_ready = shift;

    assign ybIn = sub ? ~y : y;
    assign p0In = x ^ ybIn;
    assign g0In = (x & ybIn) | {{(WIDTH-1){1'b0}}, cin & (x[0] | ybIn[0])};

    // Pipeline stage registers; data only moves when a valid operation does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= NMID; j++) begin
                gR[j]   <= {WIDTH{1'b0}};
                pR[j]   <= {WIDTH{1'b0}};
                p0R[j]  <= {WIDTH{1'b0}};
                cinR[j] <= 1'b0;
                vR[j]   <= 1'b0;
            end
        end else begin
            if (flush) begin
                vR[0] <= 1'b0;
            end else if (adv) begin
                vR[0] <= in_valid;
            end
            if (shift && in_valid) begin
                gR[0]   <= g0In;
                pR[0]   <= p0In;
                p0R[0]  <= p0In;
                cinR[0] <= cin;
            end
            for (int j = 1; j <= NMID; j++) begin
                if (flush) begin
                    vR[j] <= 1'b0;
                end else if (adv) begin
                    vR[j] <= vR[j-1];
                end
                if (shift && vR[j-1]) begin
                    gR[j]   <= gOut[j-1];
                    pR[j]   <= pOut[j-1];
                    p0R[j]  <= p0R[j-1];
                    cinR[j] <= cinR[j-1];
                end
            end
        end
    end

    // Prefix levels between registers; span doubles every level.
    always_comb begin
        logic [WIDTH-1:0] gCur;
        logic [WIDTH-1:0] pCur;
        logic [WIDTH-1:0] gNew;
        logic [WIDTH-1:0] pNew;
        int               span;
        gCur = {WIDTH{1'b0}};
        pCur = {WIDTH{1'b0}};
        gNew = {WIDTH{1'b0}};
        pNew = {WIDTH{1'b0}};
        span = 0;
        for (int j = 0; j <= NMID; j++) begin
            gCur = gR[j];
            pCur = pR[j];
            for (int k = j * REG_EVERY + 1; (k <= (j + 1) * REG_EVERY) && (k <= L); k++) begin
                span = 32'd1 << (k - 1);
                gNew = gCur;
                pNew = pCur;
                for (int i = span; i < WIDTH; i++) begin
                    gNew[i] = gCur[i] | (pCur[i] & gCur[i - span]);
                    pNew[i] = pCur[i] & pCur[i - span];
                end
                gCur = gNew;
                pCur = pNew;
            end
            gOut[j] = gCur;
            pOut[j] = pCur;
        end
    end

    assign lastG   = gOut[NMID];
    assign sumNext = p0R[NMID] ^ {lastG[WIDTH-2:0], cinR[NMID]};

    // Output register: result holds while stalled and after it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValidR <= 1'b0;
            sR        <= {WIDTH{1'b0}};
            coutR     <= 1'b0;
        end else begin
            if (flush) begin
                outValidR <= 1'b0;
            end else if (adv) begin
                outValidR <= vR[NMID];
            end
            if (shift && vR[NMID]) begin
                sR    <= sumNext;
                coutR <= lastG[WIDTH-1];
            end
        end
    end

    assign out_valid = outValidR;
    assign s         = sR;
    assign cout      = coutR;

`ifdef PREFIX_ADD_OVF_EN
    logic ovfR;

    // Signed overflow is the carry into the MSB differing from the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovfR <= 1'b0;
        end else if (shift && vR[NMID]) begin
            ovfR <= lastG[WIDTH-1] ^ lastG[WIDTH-2];
        end
    end

    assign ovf = ovfR;
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder (WIDTH=16, REG_EVERY=2).
module tb_pipelined_prefix_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef PREFIX_ADD_OVF_EN
    logic         ovf;
`endif

    exp_t sbq[$];
    exp_t monE;
    int   compared   = 0;
    int   mismatched = 0;

    pipelined_prefix_adder #(.WIDTH(W), .REG_EVERY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
`ifdef PREFIX_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one operation and record its hand-computed result on acceptance.
    task automatic sendOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input logic [W-1:0] es, input logic ec);
        int   waitCnt;
        logic [W-1:0] yb;
        exp_t e;
        waitCnt = 0;
        @(negedge clk);
        x = a; y = b; cin = ci; sub = sb; in_valid = 1'b1;
        #1;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: actual=in_ready low required=accepted within 50 cycles");
        end else begin
            @(posedge clk);
            yb  = sb ? ~b : b;
            e.s = es;
            e.c = ec;
            e.o = (a[W-1] == yb[W-1]) && (es[W-1] != a[W-1]);
            sbq.push_back(e);
        end
    endtask

    // Expect out_valid low, low, then high on the cycles after acceptance.
    task automatic latencyCheck(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        #2 check({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #2 check({name, "_lat2"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #2 check({name, "_lat3"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, sbq.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each result on the cycle it is consumed.
    always @(negedge clk) begin
        #2;
        if (!rst && !flush && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: actual=s %0h with nothing pending required=no output", s);
            end else begin
                monE = sbq.pop_front();
                check("sum", {16'd0, s}, {16'd0, monE.s});
                check("cout", {31'd0, cout}, {31'd0, monE.c});
`ifdef PREFIX_ADD_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, monE.o});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = 16'h0000; y = 16'h0000; cin = 1'b0; sub = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef PREFIX_ADD_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #2 check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Carry ripples through every bit.
        sendOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        latencyCheck("wrap");
        drain("t2");

        // Subtract with borrow / no borrow and boundary cases.
        sendOp(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        sendOp(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        sendOp(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        sendOp(16'hA5A5, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 1'b1);
        sendOp(16'h1357, 16'h2468, 1'b0, 1'b0, 16'h37BF, 1'b0);
        drain("t3");

        // Back-to-back issue with a two-cycle output stall.
        fork
            begin
                sendOp(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
                sendOp(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0);
                sendOp(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0);
                sendOp(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0);
            end
            begin
                for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
                out_ready = 1'b0;
                #2;
                check("stall1_s", {16'd0, s}, 32'h0002);
                check("stall1_in_ready", {31'd0, in_ready}, 32'd0);
                check("stall1_out_valid", {31'd0, out_valid}, 32'd1);
                @(negedge clk);
                #2;
                check("stall2_s", {16'd0, s}, 32'h0002);
                check("stall2_in_ready", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain("t4");

        // Reset with two operations in flight.
        sendOp(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0);
        sendOp(16'h0400, 16'h0500, 1'b0, 1'b0, 16'h0900, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_s", {16'd0, s}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        #2 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);

        // Flush with two in flight; the input held during flush is refused.
        sendOp(16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0);
        sendOp(16'h0044, 16'h0055, 1'b0, 1'b0, 16'h0099, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        sbq.delete();
        #2 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #2 check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) @(negedge clk);
        sendOp(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
        latencyCheck("postflush");
        drain("t5");

`ifdef PREFIX_ADD_OVF_EN
        sendOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        sendOp(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1);
        drain("t6");
`endif

        check("final_queue_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
